// File: rtl/lamp_sequence_monitor_if.sv
// Lamp observation bus: six lamp lines and fault clear in, decoded mode/fault status out.
// Latency: none, wiring only.
// Backpressure: none, the lamp lines are free-running levels with no handshake.
interface lamp_sequence_monitor_if;
    logic [2:0] left_lamp;
    logic [2:0] right_lamp;
    logic       clr_fault;
    logic [1:0] mode;
    logic       mode_valid;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] seq_count;

    // Lamp driver / harness side
    modport master (
        output left_lamp, right_lamp, clr_fault,
        input  mode, mode_valid, fault, fault_code, seq_count
    );

    // Monitor side
    modport slave (
        input  left_lamp, right_lamp, clr_fault,
        output mode, mode_valid, fault, fault_code, seq_count
    );
endinterface

// File: rtl/lamp_sequence_monitor.sv
// Sequential tail-light monitor: decodes idle/left/right/hazard and flags sticky faults.
// Latency: every response is registered 2 clock edges after the lamp lines change.
// Backpressure: none, a pure observer that samples the lamps every clock.
module lamp_sequence_monitor #(
    parameter int MAX_HOLD    = 200,
    parameter int IDLE_CYCLES = 400,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lamp_sequence_monitor_if.slave lamps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_HAZARD,
        S_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_PATTERN = 2'b01;
    localparam logic [1:0] FC_STEP    = 2'b10;
    localparam logic [1:0] FC_STUCK   = 2'b11;

    // Only the thermometer fills from the inside out are meaningful lamp images.
    function automatic logic legal_pat(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    // One side may hold, grow by one lamp, or drop from full to dark.
    function automatic logic legal_step(input logic [2:0] a, input logic [2:0] b);
        return (a == b) ||
               (a == 3'b000 && b == 3'b001) ||
               (a == 3'b001 && b == 3'b011) ||
               (a == 3'b011 && b == 3'b111) ||
               (a == 3'b111 && b == 3'b000);
    endfunction

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            S_LEFT:   return 2'b01;
            S_RIGHT:  return 2'b10;
            S_HAZARD: return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    state_t           state;
    logic [5:0]       s1;
    logic [5:0]       prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       mode_q;
    logic             mode_valid_q;
    logic             fault_q;
    logic [1:0]       fault_code_q;
    logic [7:0]       seq_count_q;

    logic [2:0] l_now, r_now, l_old, r_old;
    logic       chg, l_chg, r_chg, both_zero_old;
    logic       l_start, r_start, l_done, r_done;
    logic       pat_err, base_err, step_err, stuck, idle_hit, done, any_fault;
    logic [1:0] new_code;
    state_t     nxt;

    assign l_now         = s1[5:3];
    assign r_now         = s1[2:0];
    assign l_old         = prev[5:3];
    assign r_old         = prev[2:0];
    assign l_chg         = (l_now != l_old);
    assign r_chg         = (r_now != r_old);
    assign chg           = l_chg || r_chg;
    assign both_zero_old = (prev == 6'd0);
    assign l_start       = (l_old == 3'b000) && (l_now == 3'b001);
    assign r_start       = (r_old == 3'b000) && (r_now == 3'b001);
    assign l_done        = (l_old == 3'b111) && (l_now == 3'b000);
    assign r_done        = (r_old == 3'b111) && (r_now == 3'b000);

    // Classify the current sample against the previous one and pick the next mode.
    always_comb begin
        nxt      = state;
        step_err = 1'b0;
        done     = 1'b0;
        pat_err  = !legal_pat(l_now) || !legal_pat(r_now);
        base_err = chg && (!legal_step(l_old, l_now) || !legal_step(r_old, r_now));
        stuck    = !chg && (s1 != 6'd0) && (hold_cnt == CNT_W'(MAX_HOLD));
        idle_hit = !chg && (s1 == 6'd0) && (hold_cnt == CNT_W'(IDLE_CYCLES));
        case (state)
            S_IDLE: begin
                step_err = base_err;
                if (l_start && r_start)
                    nxt = S_HAZARD;
                else if (l_start && !r_chg && r_now == 3'b000)
                    nxt = S_LEFT;
                else if (r_start && !l_chg && l_now == 3'b000)
                    nxt = S_RIGHT;
            end
            S_LEFT: begin
                step_err = base_err;
                done     = l_done;
                if (r_chg) begin
                    // Leaving a turn is only allowed from the fully dark boundary.
                    if (both_zero_old && r_start && l_now == 3'b000)
                        nxt = S_RIGHT;
                    else if (both_zero_old && r_start && l_start)
                        nxt = S_HAZARD;
                    else
                        step_err = 1'b1;
                end else if (idle_hit) begin
                    nxt = S_IDLE;
                end
            end
            S_RIGHT: begin
                step_err = base_err;
                done     = r_done;
                if (l_chg) begin
                    if (both_zero_old && l_start && r_now == 3'b000)
                        nxt = S_LEFT;
                    else if (both_zero_old && l_start && r_start)
                        nxt = S_HAZARD;
                    else
                        step_err = 1'b1;
                end else if (idle_hit) begin
                    nxt = S_IDLE;
                end
            end
            S_HAZARD: begin
                // Both sides move in lock step to identical images.
                step_err = base_err || (chg && (!l_chg || !r_chg || l_now != r_now));
                done     = l_done && r_done;
                if (idle_hit)
                    nxt = S_IDLE;
            end
            default: begin
                nxt = state;
            end
        endcase
        any_fault = (state != S_FAULT) && (pat_err || step_err || stuck);
        if (pat_err)
            new_code = FC_PATTERN;
        else if (step_err)
            new_code = FC_STEP;
        else
            new_code = FC_STUCK;
    end

    // Two-stage lamp sampler and the hold counter that times stuck and idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 6'd0;
            prev     <= 6'd0;
            hold_cnt <= '0;
        end else begin
            s1   <= {lamps.left_lamp, lamps.right_lamp};
            prev <= s1;
            if (state == S_FAULT && lamps.clr_fault)
                hold_cnt <= '0;
            else if (chg)
                hold_cnt <= '0;
            else if (~&hold_cnt)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Mode FSM with registered status outputs; faults are sticky until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mode_q       <= 2'b00;
            mode_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            seq_count_q  <= 8'd0;
        end else if (state == S_FAULT) begin
            if (lamps.clr_fault) begin
                state        <= S_IDLE;
                fault_q      <= 1'b0;
                fault_code_q <= FC_NONE;
            end
        end else if (any_fault) begin
            state        <= S_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= new_code;
            mode_valid_q <= 1'b0;
        end else begin
            state <= nxt;
            if (done) begin
                mode_q       <= mode_of(state);
                mode_valid_q <= 1'b1;
                if (seq_count_q != 8'hFF)
                    seq_count_q <= seq_count_q + 8'd1;
            end else if (nxt != state) begin
                if (nxt == S_IDLE) begin
                    mode_q       <= 2'b00;
                    mode_valid_q <= 1'b1;
                end else begin
                    mode_valid_q <= 1'b0;
                end
            end else if (state == S_IDLE && idle_hit) begin
                mode_q       <= 2'b00;
                mode_valid_q <= 1'b1;
            end
        end
    end

    assign lamps.mode       = mode_q;
    assign lamps.mode_valid = mode_valid_q;
    assign lamps.fault      = fault_q;
    assign lamps.fault_code = fault_code_q;
    assign lamps.seq_count  = seq_count_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for the lamp sequence monitor with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after an edge.
// Backpressure: none, lamps are driven as free-running levels.
module tb_lamp_sequence_monitor;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    lamp_sequence_monitor_if bus ();

    lamp_sequence_monitor #(
        .MAX_HOLD    (8),
        .IDLE_CYCLES (16),
        .CNT_W       (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lamps (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] l, input logic [2:0] r, input int n);
        bus.left_lamp  = l;
        bus.right_lamp = r;
        tick(n);
    endtask

    task automatic pulse_clr();
        bus.clr_fault = 1'b1;
        tick(1);
        bus.clr_fault = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        bus.left_lamp  = 3'b000;
        bus.right_lamp = 3'b000;
        bus.clr_fault  = 1'b0;

        // Reset values
        #3;
        check("rst_mode",       8'(bus.mode),       8'd0);
        check("rst_mode_valid", 8'(bus.mode_valid), 8'd0);
        check("rst_fault",      8'(bus.fault),      8'd0);
        check("rst_fault_code", 8'(bus.fault_code), 8'd0);
        check("rst_seq_count",  bus.seq_count,      8'd0);
        tick(2);
        rst_n = 1'b1;

        // Idle confirmation after 16 quiet cycles
        tick(8);
        check("idle_early_valid", 8'(bus.mode_valid), 8'd0);
        tick(12);
        check("idle_valid", 8'(bus.mode_valid), 8'd1);
        check("idle_mode",  8'(bus.mode),       8'd0);
        check("idle_fault", 8'(bus.fault),      8'd0);

        // Left turn sequences
        drive(3'b001, 3'b000, 4);
        check("left_enter_valid", 8'(bus.mode_valid), 8'd0);
        drive(3'b011, 3'b000, 4);
        drive(3'b111, 3'b000, 4);
        drive(3'b000, 3'b000, 2);
        check("left1_mode",  8'(bus.mode),       8'd1);
        check("left1_valid", 8'(bus.mode_valid), 8'd1);
        check("left1_seq",   bus.seq_count,      8'd1);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 3'b000, 4);
            drive(3'b011, 3'b000, 4);
            drive(3'b111, 3'b000, 4);
            drive(3'b000, 3'b000, 4);
        end
        check("left4_seq",  bus.seq_count, 8'd4);
        check("left4_mode", 8'(bus.mode),  8'd1);
        check("left4_fault", 8'(bus.fault), 8'd0);

        // Hazard sequence from a fresh reset, then a mismatched step
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rst2_seq", bus.seq_count, 8'd0);
        drive(3'b001, 3'b001, 4);
        check("haz_enter_valid", 8'(bus.mode_valid), 8'd0);
        drive(3'b011, 3'b011, 4);
        drive(3'b111, 3'b111, 4);
        drive(3'b000, 3'b000, 2);
        check("haz_mode",  8'(bus.mode),       8'd3);
        check("haz_valid", 8'(bus.mode_valid), 8'd1);
        check("haz_seq",   bus.seq_count,      8'd1);
        tick(2);
        drive(3'b011, 3'b001, 2);
        check("haz_step_fault", 8'(bus.fault),      8'd1);
        check("haz_step_code",  8'(bus.fault_code), 8'd2);
        check("haz_step_valid", 8'(bus.mode_valid), 8'd0);
        check("haz_step_mode",  8'(bus.mode),       8'd3);

        // Illegal pattern, clear while still present, then clear cleanly
        drive(3'b000, 3'b000, 3);
        pulse_clr();
        check("clr1_fault", 8'(bus.fault),      8'd0);
        check("clr1_code",  8'(bus.fault_code), 8'd0);
        tick(3);
        drive(3'b010, 3'b000, 2);
        check("pat_fault", 8'(bus.fault),      8'd1);
        check("pat_code",  8'(bus.fault_code), 8'd1);
        pulse_clr();
        check("pat_clr_fault", 8'(bus.fault), 8'd0);
        tick(1);
        check("pat_reassert_fault", 8'(bus.fault),      8'd1);
        check("pat_reassert_code",  8'(bus.fault_code), 8'd1);
        drive(3'b000, 3'b000, 3);
        pulse_clr();
        check("clr2_fault", 8'(bus.fault), 8'd0);
        tick(4);
        check("clr2_stays", 8'(bus.fault), 8'd0);

        // Stuck lamp: 011 held until the hold counter reaches 8
        drive(3'b001, 3'b000, 2);
        drive(3'b011, 3'b000, 10);
        check("stuck_early", 8'(bus.fault), 8'd0);
        tick(2);
        check("stuck_fault", 8'(bus.fault),      8'd1);
        check("stuck_code",  8'(bus.fault_code), 8'd3);
        drive(3'b000, 3'b000, 3);
        check("stuck_sticky_fault", 8'(bus.fault),      8'd1);
        check("stuck_sticky_code",  8'(bus.fault_code), 8'd3);

        // Left completes, then right takes over directly, then reset mid-sequence
        pulse_clr();
        check("clr3_fault", 8'(bus.fault), 8'd0);
        tick(2);
        drive(3'b001, 3'b000, 4);
        drive(3'b011, 3'b000, 4);
        drive(3'b111, 3'b000, 4);
        drive(3'b000, 3'b000, 4);
        check("left5_mode", 8'(bus.mode),  8'd1);
        check("left5_seq",  bus.seq_count, 8'd2);
        drive(3'b000, 3'b001, 4);
        check("right_enter_valid", 8'(bus.mode_valid), 8'd0);
        check("right_enter_mode",  8'(bus.mode),       8'd1);
        drive(3'b000, 3'b011, 4);
        drive(3'b000, 3'b111, 4);
        drive(3'b000, 3'b000, 2);
        check("right_mode",  8'(bus.mode),       8'd2);
        check("right_valid", 8'(bus.mode_valid), 8'd1);
        check("right_seq",   bus.seq_count,      8'd3);
        tick(2);
        drive(3'b000, 3'b001, 4);
        drive(3'b000, 3'b011, 3);
        rst_n = 1'b0;
        #2;
        check("arst_mode",  8'(bus.mode),       8'd0);
        check("arst_valid", 8'(bus.mode_valid), 8'd0);
        check("arst_fault", 8'(bus.fault),      8'd0);
        check("arst_code",  8'(bus.fault_code), 8'd0);
        check("arst_seq",   bus.seq_count,      8'd0);
        bus.left_lamp  = 3'b000;
        bus.right_lamp = 3'b000;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("resync_fault", 8'(bus.fault),      8'd0);
        check("resync_valid", 8'(bus.mode_valid), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
- Observer at the far end of the turn-signal lamp interface. Samples the six lamp lines (3 left, 3 right) every clock and decodes which mode is running: idle, left, right or hazard.
- Checks every lamp transition against the legal sequential-tail-light sequence. Raises a sticky fault on an illegal pattern, an illegal step or a stuck lamp.
- Used on-chip as a self-check beside the lamp controller, or on a bench/harness board that watches real lamp drivers.

Parameters:
- MAX_HOLD, 200, maximum cycles a non-zero pattern may hold before a stuck fault.
- IDLE_CYCLES, 400, cycles with both sides 000 before mode reports idle.
- CNT_W, 10, width of the hold counter. Must satisfy 2^CNT_W > max(MAX_HOLD, IDLE_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- left_lamp  input  3  left lamps; bit0 innermost, bit2 outermost.
- right_lamp  input  3  right lamps; same bit order.
- clr_fault  input  1  synchronous pulse; clears fault and fault_code.
- mode  output  2  00 idle, 01 left, 10 right, 11 hazard.
- mode_valid  output  1  mode has been confirmed.
- fault  output  1  sticky fault flag.
- fault_code  output  2  00 none, 01 illegal pattern, 10 illegal step, 11 stuck.
- seq_count  output  8  completed sequences; saturates at 255.

Behaviour:
- Reset (asynchronous, rst_n low): all registers clear. State S_IDLE, mode=00, mode_valid=0, fault=0, fault_code=00, seq_count=0, hold counter=0, input stages=000/000.
- Input pipeline: s1 <= {left_lamp,right_lamp}; prev <= s1. Checks compare s1 against prev. Outputs are registered, so each response appears 2 clock edges after the input change.
- Legal per-side patterns: 000, 001, 011, 111. Any other value on either side sets fault_code=01.
- Legal per-side steps: hold, 000->001, 001->011, 011->111, 111->000. Any other change sets fault_code=10.
- Hold counter: resets to 0 on any change of s1 versus prev; otherwise increments, saturating at all-ones.
- States: S_IDLE, S_LEFT, S_RIGHT, S_HAZARD, S_FAULT.
- S_IDLE:
  - Left steps 000->001 while right holds 000 -> S_LEFT.
  - Right steps 000->001 while left holds 000 -> S_RIGHT.
  - Both step 000->001 in the same cycle -> S_HAZARD.
  - When both sides have been 000 for IDLE_CYCLES cycles: mode=00, mode_valid=1.
- S_LEFT / S_RIGHT: the inactive side must hold 000. Any change on it is fault 10, except when both sides are 000 at the boundary:
  - The other side stepping 000->001 switches state directly to the other turn state.
  - Both sides stepping together switches to S_HAZARD.
- S_HAZARD: both sides must change in the same cycle, to identical values. A one-sided change, or left != right, is fault 10.
- Sequence completion: each 111->000 step in the current state sets mode to that state's code, sets mode_valid=1 and increments seq_count.
- On entering a new turn/hazard state, mode_valid=0 until that state's first completion.
- Return to idle: both sides 000 for IDLE_CYCLES -> S_IDLE.
- Stuck: a non-zero pattern held for MAX_HOLD cycles (hold counter == MAX_HOLD) sets fault_code=11.
- Fault handling:
  - Any fault -> S_FAULT, fault=1, mode_valid=0; mode keeps its last value.
  - Fault priority when several occur in one cycle: 01 > 10 > 11.
  - fault and fault_code are sticky; later faults do not overwrite fault_code.
- clr_fault in S_FAULT:
  - Next edge clears fault and fault_code and forces S_IDLE.
  - The hold counter restarts at 0.
  - Checks resume with the next change.
  - If an illegal pattern is still present, fault 01 re-asserts on the following cycle.
- clr_fault outside S_FAULT: no effect.
- In S_FAULT, steps are not checked and seq_count does not increment.
- Reset mid-sequence: immediate return to the reset values above; the next edges resynchronise from 000/000.

Test Plan:
- MAX_HOLD=8, IDLE_CYCLES=16. After reset, both sides held 000 for 20 cycles -> mode=00, mode_valid=1 at cycle 18 after the first sample; fault=0.
- Left steps 001,011,111,000, each held 4 cycles, right held 000 -> S_LEFT; mode=01, mode_valid=1 and seq_count=1 two edges after 000 is applied. Three more sequences -> seq_count=4.
- Both sides stepped together 001,011,111,000 -> mode=11, seq_count=1. Then left=011 with right=001 -> fault=1, fault_code=10, mode_valid=0.
- Left=010 applied -> fault_code=01 two edges later. Keep 010 and pulse clr_fault -> fault clears for one cycle, then re-asserts with 01. Restore 000, pulse clr_fault -> fault=0, state S_IDLE.
- Left held at 011 for 12 cycles -> fault_code=11 when the hold counter reaches 8. Then left 011->000 while in fault -> no change, fault_code stays 11.
- Left sequence completes; both sides 000; then right steps 001 -> S_RIGHT, mode_valid=0. Right completes -> mode=10. Assert rst_n=0 mid-sequence at right=011 -> all outputs go to reset values immediately, without waiting for a clock edge.
